ts_usb_writer: RTL and testbench
================================

TS_USB_WRITER -- requirements
Module: ts_usb_writer

Interface
REQ-001 Parameter FIFO_AW, default 3, log2 of word-FIFO depth (depth 8).
REQ-002 Parameter PKT_WORDS, default 256, words per full USB packet.
REQ-003 Parameter PKT_TIMEOUT, default 4096, idle IFCLK cycles before short-packet commit.
REQ-004 IFCLK  in  1  interface clock; all logic on rising edge.
REQ-005 REQ_CLR  in  1  reset REQ_CLR, asynchronous, active-high.
REQ-006 REQ  in  1  upstream word-ready level from SCLK domain; held high until acknowledged.
REQ-007 TS_DATA  in  16  upstream word; stable while REQ high.
REQ-008 WORD_ACK  out  1  one-cycle pulse; upstream clears its request on it.
REQ-009 FULL_N  in  1  USB slave-FIFO full flag, active-low, asynchronous.
REQ-010 FD  out  16  USB slave-FIFO data.
REQ-011 SLWR_N  out  1  USB slave-FIFO write strobe, active-low.
REQ-012 PKTEND_N  out  1  USB short-packet commit, active-low.
REQ-013 LEVEL  out  FIFO_AW+1  current word-FIFO occupancy.
REQ-014 OVF  out  1  sticky overflow flag.

Function
REQ-015 REQ and FULL_N each pass a two-flop synchronizer before use.
REQ-016 Capture on rising edge of synchronized REQ: TS_DATA pushed into FIFO in the detect cycle (3rd IFCLK edge after REQ rises).
REQ-017 WORD_ACK high exactly one cycle, the cycle after capture; no further capture until synchronized REQ has been seen low.
REQ-018 FIFO full at capture: word dropped, OVF set to 1, WORD_ACK still issued; OVF cleared only by reset.
REQ-019 Same-cycle push and pop both take effect; LEVEL unchanged.
REQ-020 FIFO pointers FIFO_AW bits, wrap modulo depth; LEVEL range 0..2^FIFO_AW.
REQ-021 Write FSM states IDLE, WRITE, PEND; reset state IDLE.
REQ-022 IDLE->WRITE when LEVEL>0 and synchronized FULL_N=1; FD loaded with FIFO head on that edge.
REQ-023 WRITE: SLWR_N low one cycle, head popped, packet word counter +1; next state IDLE; FD holds value through the SLWR_N low cycle and the following cycle.
REQ-024 Packet counter reaching PKT_WORDS resets to 0 with no PKTEND_N (host auto-commits).
REQ-025 Idle counter counts cycles in IDLE with LEVEL=0 and packet counter nonzero; cleared by any push or any WRITE.
REQ-026 IDLE->PEND when idle counter reaches PKT_TIMEOUT and synchronized FULL_N=1; if FULL_N=0, wait in IDLE with counter saturated.
REQ-027 PEND: PKTEND_N low one cycle, packet and idle counters cleared, next state IDLE.
REQ-028 Pending push during PEND is accepted normally; LEVEL>0 at timeout check takes priority (WRITE over PEND).
REQ-029 SLWR_N and PKTEND_N never low in the same cycle; neither low while synchronized FULL_N=0 at the decision edge.
REQ-030 Minimum interval between SLWR_N pulses: 2 cycles.

Reset
REQ-031 REQ_CLR high forces immediately: FD=0, SLWR_N=1, PKTEND_N=1, WORD_ACK=0, OVF=0, LEVEL=0, pointers and counters 0, synchronizers 0, state IDLE.
REQ-032 REQ_CLR asserted mid-WRITE aborts the strobe (SLWR_N returns to 1 asynchronously); FIFO contents discarded.
REQ-033 After release, a REQ already high is captured once (synchronizer starts at 0, so rising edge seen).

Verification
REQ-034 Single word: REQ high with TS_DATA=0x47A5, FULL_N=1 -> capture at edge 3, WORD_ACK at edge 4, SLWR_N low with FD=0x47A5 within 3 further cycles, LEVEL back to 0.
REQ-035 Overflow: FULL_N=0, 9 handshaked words -> LEVEL=8, 9th word dropped, OVF=1, 9 WORD_ACK pulses; FULL_N=1 -> 8 SLWR_N pulses in push order.
REQ-036 Short packet: 5 words then idle -> PKTEND_N low once exactly PKT_TIMEOUT cycles after the last SLWR_N plus state-transition cycle; no PKTEND_N after 256-word burst.
REQ-037 Simultaneous push/pop at LEVEL=3 -> LEVEL stays 3, data order preserved across pointer wrap (20 words through depth 8).
REQ-038 REQ_CLR pulse during SLWR_N low -> all outputs at reset values same cycle; following word delivered correctly with packet counter restarted.

Source files
------------

// File: rtl/ts_usb_writer.sv
// ts_usb_writer: buffers handshaked 16-bit words and drives a USB slave-FIFO with
// full-packet auto-commit and a timeout-driven short-packet commit.
module ts_usb_writer #(
  parameter int FIFO_AW     = 3,
  parameter int PKT_WORDS   = 256,
  parameter int PKT_TIMEOUT = 4096
) (
  input  logic               IFCLK,
  input  logic               REQ_CLR,
  input  logic               REQ,
  input  logic [15:0]        TS_DATA,
  output logic               WORD_ACK,
  input  logic               FULL_N,
  output logic [15:0]        FD,
  output logic               SLWR_N,
  output logic               PKTEND_N,
  output logic [FIFO_AW:0]   LEVEL,
  output logic               OVF
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = $clog2(PKT_WORDS + 1);
  localparam int TW    = $clog2(PKT_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WRITE, PEND} state_t;
  state_t               state;
  logic                 req_s1, req_s2, req_d, full_s1, full_s2;
  logic [15:0]          mem [DEPTH];
  logic [FIFO_AW-1:0]   wp, rp;
  logic [PW-1:0]        pkt_cnt;
  logic [TW-1:0]        idle_cnt;
  logic                 capture, push, pop;
  assign capture = req_s2 & ~req_d;
  assign push    = capture & (LEVEL != (FIFO_AW+1)'(DEPTH));
  assign pop     = state == WRITE;
  // Storage needs no reset: pointers and LEVEL define which entries are valid.
  always_ff @(posedge IFCLK)
    if (push) mem[wp] <= TS_DATA;
  always_ff @(posedge IFCLK or posedge REQ_CLR) begin
    if (REQ_CLR) begin
      req_s1   <= 1'b0;
      req_s2   <= 1'b0;
      req_d    <= 1'b0;
      full_s1  <= 1'b0;
      full_s2  <= 1'b0;
      WORD_ACK <= 1'b0;
      OVF      <= 1'b0;
      wp       <= '0;
      rp       <= '0;
      LEVEL    <= '0;
      FD       <= '0;
      SLWR_N   <= 1'b1;
      PKTEND_N <= 1'b1;
      pkt_cnt  <= '0;
      idle_cnt <= '0;
      state    <= IDLE;
    end else begin
      req_s1   <= REQ;
      req_s2   <= req_s1;
      req_d    <= req_s2;
      full_s1  <= FULL_N;
      full_s2  <= full_s1;
      WORD_ACK <= capture;
      if (capture && !push) OVF <= 1'b1;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      LEVEL <= LEVEL + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
      unique case (state)
        IDLE:
          if (LEVEL != 0 && full_s2) begin
            state  <= WRITE;
            FD     <= mem[rp];
            SLWR_N <= 1'b0;
          end else if (idle_cnt == TW'(PKT_TIMEOUT) && full_s2) begin
            state    <= PEND;
            PKTEND_N <= 1'b0;
          end else if (push) begin
            idle_cnt <= '0;
          end else if (LEVEL == 0 && pkt_cnt != 0 && idle_cnt != TW'(PKT_TIMEOUT)) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        WRITE: begin
          SLWR_N   <= 1'b1;
          pkt_cnt  <= (pkt_cnt == PW'(PKT_WORDS - 1)) ? '0 : pkt_cnt + 1'b1;
          idle_cnt <= '0;
          state    <= IDLE;
        end
        PEND: begin
          PKTEND_N <= 1'b1;
          pkt_cnt  <= '0;
          idle_cnt <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ts_usb_writer.sv
// tb_ts_usb_writer: randomized self-checking bench for ts_usb_writer against a
// word-order / packet-timing reference model.
module tb_ts_usb_writer;
  localparam int AW = 3, PW = 256, TO = 4096, DEPTH = 8;
  logic        IFCLK = 0, REQ_CLR = 1, REQ = 0, FULL_N = 1;
  logic [15:0] TS_DATA = '0;
  logic        WORD_ACK, SLWR_N, PKTEND_N, OVF;
  logic [15:0] FD;
  logic [AW:0] LEVEL;
  ts_usb_writer #(.FIFO_AW(AW), .PKT_WORDS(PW), .PKT_TIMEOUT(TO)) dut (
    .IFCLK(IFCLK), .REQ_CLR(REQ_CLR), .REQ(REQ), .TS_DATA(TS_DATA),
    .WORD_ACK(WORD_ACK), .FULL_N(FULL_N), .FD(FD), .SLWR_N(SLWR_N),
    .PKTEND_N(PKTEND_N), .LEVEL(LEVEL), .OVF(OVF)
  );
  always #5 IFCLK = ~IFCLK;
  int checks = 0, errors = 0, cyc = 0;
  int ack_cnt = 0, pend_cnt = 0, last_slwr = 0, last_pend = 0;
  logic [15:0] got_q[$], exp_q[$];
  always @(posedge IFCLK) cyc <= cyc + 1;
  always @(negedge IFCLK) if (!REQ_CLR) begin
    if (!SLWR_N) begin got_q.push_back(FD); last_slwr = cyc; end
    if (!PKTEND_N) begin pend_cnt++; last_pend = cyc; end
    if (WORD_ACK) ack_cnt++;
    if (!SLWR_N && !PKTEND_N) begin errors++; $display("FAIL strobe_overlap: SLWR_N=0 and PKTEND_N=0 at cycle %0d, required not both low", cyc); end
  end
  initial begin #3ms; $display("FAIL watchdog: simulation time limit reached"); $fatal(1); end
  function automatic bit qsame();
    if (got_q.size() != exp_q.size()) return 0;
    foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return 0;
    return 1;
  endfunction
  task automatic clr_q();
    got_q.delete(); exp_q.delete(); ack_cnt = 0; pend_cnt = 0;
  endtask
  task automatic do_reset();
    @(negedge IFCLK); REQ_CLR = 1; REQ = 0; FULL_N = 1;
    repeat (2) @(negedge IFCLK);
    REQ_CLR = 0; clr_q();
  endtask
  task automatic send(input logic [15:0] d);
    bit ok = 0;
    TS_DATA = d; REQ = 1;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge IFCLK); if (WORD_ACK) ok = 1; end
    REQ = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL send_ack: no WORD_ACK within 20 cycles for word %h", d); end
    repeat (3) @(negedge IFCLK);
  endtask
  task automatic test_reset();
    logic [15:0] d = 16'($urandom);
    REQ_CLR = 1; REQ = 1; TS_DATA = d;
    repeat (3) @(negedge IFCLK);
    checks++;
    if ({FD, SLWR_N, PKTEND_N, WORD_ACK, OVF, LEVEL} !== {16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0}) begin
      errors++; $display("FAIL reset_values: FD=%h SLWR_N=%b PKTEND_N=%b ACK=%b OVF=%b LEVEL=%0d, required 0,1,1,0,0,0", FD, SLWR_N, PKTEND_N, WORD_ACK, OVF, LEVEL);
    end
    REQ_CLR = 0; clr_q();
    repeat (30) @(negedge IFCLK);
    REQ = 0;
    repeat (10) @(negedge IFCLK);
    checks++;
    if (ack_cnt !== 1) begin errors++; $display("FAIL reset_req_high_acks: got %0d, required 1", ack_cnt); end
    exp_q.push_back(d);
    checks++;
    if (!qsame()) begin errors++; $display("FAIL reset_req_high_data: got %0d words, required 1 word %h", got_q.size(), d); end
  endtask
  task automatic test_single();
    int sk = 0;
    logic [15:0] sfd = '0, hfd = '0;
    do_reset();
    TS_DATA = 16'h47A5; REQ = 1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge IFCLK);
      if (k <= 4) begin
        checks++;
        if (WORD_ACK !== (k == 3)) begin errors++; $display("FAIL single_ack_edge%0d: got %b, required %b", k, WORD_ACK, k == 3); end
      end
      if (k == 3) REQ = 0;
      if (sk != 0 && k == sk + 1) hfd = FD;
      if (!SLWR_N && sk == 0) begin sk = k; sfd = FD; end
    end
    checks++;
    if (sk < 4 || sk > 7) begin errors++; $display("FAIL single_slwr_time: first SLWR_N low at edge %0d, required 4..7", sk); end
    checks++;
    if (sfd !== 16'h47A5) begin errors++; $display("FAIL single_fd: got %h, required 47a5", sfd); end
    checks++;
    if (hfd !== 16'h47A5) begin errors++; $display("FAIL single_fd_hold: got %h, required 47a5", hfd); end
    checks++;
    if (LEVEL !== 0) begin errors++; $display("FAIL single_level: got %0d, required 0", LEVEL); end
  endtask
  task automatic test_overflow();
    bit ovf_m = 0;
    do_reset();
    FULL_N = 0;
    repeat (3) @(negedge IFCLK);
    for (int i = 0; i < 9; i++) begin
      logic [15:0] d = 16'($urandom);
      send(d);
      if (exp_q.size() < DEPTH) exp_q.push_back(d); else ovf_m = 1;
    end
    repeat (2) @(negedge IFCLK);
    checks++;
    if (LEVEL !== DEPTH) begin errors++; $display("FAIL ovf_level: got %0d, required %0d", LEVEL, DEPTH); end
    checks++;
    if (OVF !== ovf_m) begin errors++; $display("FAIL ovf_flag: got %b, required %b", OVF, ovf_m); end
    checks++;
    if (ack_cnt !== 9) begin errors++; $display("FAIL ovf_acks: got %0d, required 9", ack_cnt); end
    checks++;
    if (got_q.size() !== 0) begin errors++; $display("FAIL ovf_no_write_while_full: got %0d writes, required 0", got_q.size()); end
    FULL_N = 1;
    repeat (40) @(negedge IFCLK);
    checks++;
    if (!qsame()) begin errors++; $display("FAIL ovf_drain_order: got %0d words, required %0d in push order", got_q.size(), exp_q.size()); end
    checks++;
    if (OVF !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, required 1", OVF); end
  endtask
  task automatic test_short_packet();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      logic [15:0] d = 16'($urandom);
      exp_q.push_back(d); send(d);
    end
    for (int i = 0; i < TO + 100 && pend_cnt == 0; i++) @(negedge IFCLK);
    repeat (20) @(negedge IFCLK);
    checks++;
    if (!qsame()) begin errors++; $display("FAIL short_data: got %0d words, required %0d", got_q.size(), exp_q.size()); end
    checks++;
    if (pend_cnt !== 1) begin errors++; $display("FAIL short_pktend_count: got %0d, required 1", pend_cnt); end
    checks++;
    if (last_pend - last_slwr !== TO + 2) begin errors++; $display("FAIL short_pktend_time: got %0d cycles after last write, required %0d", last_pend - last_slwr, TO + 2); end
  endtask
  task automatic test_burst();
    do_reset();
    for (int i = 0; i < PW; i++) begin
      logic [15:0] d = 16'($urandom);
      exp_q.push_back(d); send(d);
    end
    repeat (TO + 200) @(negedge IFCLK);
    checks++;
    if (!qsame()) begin errors++; $display("FAIL burst_data: got %0d words, required %0d", got_q.size(), exp_q.size()); end
    checks++;
    if (pend_cnt !== 0) begin errors++; $display("FAIL burst_no_pktend: got %0d PKTEND_N pulses, required 0", pend_cnt); end
    checks++;
    if (LEVEL !== 0) begin errors++; $display("FAIL burst_level: got %0d, required 0", LEVEL); end
  endtask
  task automatic test_wrap();
    logic [15:0] d;
    do_reset();
    FULL_N = 0;
    repeat (3) @(negedge IFCLK);
    for (int i = 0; i < 3; i++) begin d = 16'($urandom); exp_q.push_back(d); send(d); end
    checks++;
    if (LEVEL !== 3) begin errors++; $display("FAIL wrap_prefill: got %0d, required 3", LEVEL); end
    // FULL_N released one cycle ahead of REQ so the pop lands on the capture edge
    FULL_N = 1;
    @(negedge IFCLK);
    d = 16'($urandom); exp_q.push_back(d); TS_DATA = d; REQ = 1;
    repeat (2) @(negedge IFCLK);
    checks++;
    if ({SLWR_N, LEVEL} !== {1'b0, 4'd3}) begin errors++; $display("FAIL wrap_write_start: SLWR_N=%b LEVEL=%0d, required 0 and 3", SLWR_N, LEVEL); end
    @(negedge IFCLK);
    checks++;
    if ({WORD_ACK, LEVEL} !== {1'b1, 4'd3}) begin errors++; $display("FAIL wrap_push_pop: ACK=%b LEVEL=%0d, required 1 and 3", WORD_ACK, LEVEL); end
    REQ = 0;
    repeat (3) @(negedge IFCLK);
    for (int i = 0; i < 16; i++) begin
      FULL_N = ($urandom_range(0, 3) != 0);
      d = 16'($urandom); exp_q.push_back(d); send(d);
    end
    FULL_N = 1;
    repeat (40) @(negedge IFCLK);
    checks++;
    if (!qsame()) begin errors++; $display("FAIL wrap_order: got %0d words, required %0d in push order", got_q.size(), exp_q.size()); end
    checks++;
    if (OVF !== 1'b0) begin errors++; $display("FAIL wrap_no_ovf: got %b, required 0", OVF); end
  endtask
  task automatic test_reset_mid_write();
    logic [15:0] d;
    bit seen = 0;
    do_reset();
    TS_DATA = 16'($urandom); REQ = 1;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge IFCLK);
      if (WORD_ACK) REQ = 0;
      if (!SLWR_N) seen = 1;
    end
    REQ = 0;
    checks++;
    if (!seen) begin errors++; $display("FAIL mid_write_reach: SLWR_N never low, required low within 12 cycles"); end
    #2 REQ_CLR = 1;
    #1;
    checks++;
    if ({FD, SLWR_N, PKTEND_N, WORD_ACK, OVF, LEVEL} !== {16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0}) begin
      errors++; $display("FAIL mid_write_async_reset: FD=%h SLWR_N=%b PKTEND_N=%b ACK=%b OVF=%b LEVEL=%0d, required 0,1,1,0,0,0", FD, SLWR_N, PKTEND_N, WORD_ACK, OVF, LEVEL);
    end
    @(negedge IFCLK);
    REQ_CLR = 0; clr_q();
    d = 16'($urandom); exp_q.push_back(d); send(d);
    for (int i = 0; i < TO + 100 && pend_cnt == 0; i++) @(negedge IFCLK);
    repeat (5) @(negedge IFCLK);
    checks++;
    if (!qsame()) begin errors++; $display("FAIL mid_write_next_word: got %0d words, required 1 word %h", got_q.size(), d); end
    checks++;
    if (pend_cnt !== 1 || last_pend - last_slwr !== TO + 2) begin errors++; $display("FAIL mid_write_pkt_restart: %0d PKTEND_N at +%0d, required 1 at +%0d", pend_cnt, last_pend - last_slwr, TO + 2); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_short_packet();
    test_burst();
    test_wrap();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
